// File: rtl/ase_emul_pcie_ss_axis_wrr_sched_if.sv
// Request/grant bundle between the per-channel skid buffers, the WRR scheduler and the mux.
// A beat on channel c moves in a cycle iff grant_1hot[c] = 1, which happens only when
// req_valid[c] and out_ready are both high; grant_1hot is the skid buffer's tready.
interface ase_emul_pcie_ss_axis_wrr_sched_if #(
  parameter int NUM_CH = 2
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req_valid;
  logic [NUM_CH-1:0] req_last;
  logic              out_ready;
  logic [NUM_CH-1:0] grant_1hot;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;

  modport master (
    input  req_valid, req_last, out_ready,
    output grant_1hot, grant_idx, grant_valid
  );

  modport slave (
    output req_valid, req_last, out_ready,
    input  grant_1hot, grant_idx, grant_valid
  );
endinterface

// File: rtl/ase_emul_pcie_ss_axis_wrr_sched.sv
// Packet-aware weighted round-robin beat scheduler for the PCIe SS AXI-S mux.
// Optional starvation guard: define ASE_EMUL_PCIE_SS_SCHED_STARVE_GUARD_EN.
module ase_emul_pcie_ss_axis_wrr_sched #(
  parameter  int NUM_CH       = 2,
  parameter  int WEIGHT_W     = 4,
  parameter  int STARVE_W     = 8,
  parameter  int STARVE_LIMIT = 200,
  localparam int IDX_W        = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  ase_emul_pcie_ss_axis_wrr_sched_if.master bus,
  input  logic [NUM_CH*WEIGHT_W-1:0]     weight_cfg,
  output logic [IDX_W-1:0]               cur_ch
);

  logic [IDX_W-1:0]    cur;
  logic [WEIGHT_W-1:0] credit;
  logic                locked;
  logic [IDX_W-1:0]    lock_ch;

  logic [IDX_W-1:0]    adv_ch;
  logic                adv_found;
  logic [IDX_W:0]      rot_sum;
  logic [IDX_W-1:0]    rot_ch;

  logic [IDX_W-1:0]    sel;
  logic                sel_ok;
  logic                adv;
  logic                sel_last;
  logic                fire;
  logic [WEIGHT_W-1:0] w_raw;
  logic [WEIGHT_W-1:0] reload;

  // First requester strictly after cur, wrapping so cur itself is tried last.
  always_comb begin
    adv_found = 1'b0;
    adv_ch    = '0;
    rot_sum   = '0;
    rot_ch    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rot_sum = {1'b0, cur} + (IDX_W+1)'(k);
      if (rot_sum >= (IDX_W+1)'(NUM_CH)) rot_sum = rot_sum - (IDX_W+1)'(NUM_CH);
      rot_ch = rot_sum[IDX_W-1:0];
      if (!adv_found && bus.req_valid[rot_ch]) begin
        adv_found = 1'b1;
        adv_ch    = rot_ch;
      end
    end
  end

`ifdef ASE_EMUL_PCIE_SS_SCHED_STARVE_GUARD_EN
  logic [STARVE_W-1:0] wait_cnt [NUM_CH];
  logic                st_found;
  logic [IDX_W-1:0]    st_ch;

  always_comb begin
    st_found = 1'b0;
    st_ch    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!st_found && bus.req_valid[c] && wait_cnt[c] >= STARVE_W'(STARVE_LIMIT)) begin
        st_found = 1'b1;
        st_ch    = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n || bus.grant_1hot[c]) wait_cnt[c] <= '0;
      else if (bus.req_valid[c] && wait_cnt[c] != '1) wait_cnt[c] <= wait_cnt[c] + 1'b1;
    end
  end
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_W > 0) && (STARVE_LIMIT > 0);
`endif

  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    adv    = 1'b0;
    if (locked) begin
      sel    = lock_ch;
      sel_ok = 1'b1;
    end
`ifdef ASE_EMUL_PCIE_SS_SCHED_STARVE_GUARD_EN
    else if (st_found) begin
      sel    = st_ch;
      sel_ok = 1'b1;
      adv    = 1'b1;
    end
`endif
    else if (bus.req_valid[cur] && credit != '0) begin
      sel    = cur;
      sel_ok = 1'b1;
    end else if (adv_found) begin
      sel    = adv_ch;
      sel_ok = 1'b1;
      adv    = 1'b1;
    end
  end

  assign fire     = rst_n & bus.out_ready & sel_ok & bus.req_valid[sel];
  assign sel_last = bus.req_last[sel];
  assign w_raw    = weight_cfg[int'(sel)*WEIGHT_W +: WEIGHT_W];
  assign reload   = (w_raw == '0) ? WEIGHT_W'(1) : w_raw;

  assign bus.grant_valid = fire;
  assign bus.grant_idx   = fire ? sel : '0;
  assign bus.grant_1hot  = fire ? (NUM_CH'(1) << sel) : '0;
  assign cur_ch          = rst_n ? cur : '0;

  // A locked packet always belongs to cur, so any non-ADVANCE tlast beat spends credit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur     <= '0;
      credit  <= '0;
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (fire) begin
      locked <= !sel_last;
      if (!sel_last) lock_ch <= sel;
      if (adv) begin
        cur    <= sel;
        credit <= sel_last ? (reload - WEIGHT_W'(1)) : reload;
      end else if (sel_last && credit != '0) begin
        credit <= credit - WEIGHT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ase_emul_pcie_ss_axis_wrr_sched.sv
// Directed bench for the WRR scheduler: 2-channel vector table plus multi-cycle sequences
// (ratio, 3-channel weight-0 rotation, starvation).
module tb_ase_emul_pcie_ss_axis_wrr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  weight2;
  logic [11:0] weight3;
  logic [0:0]  cur2;
  logic [1:0]  cur3;

  int n_cmp  = 0;
  int n_miss = 0;

  ase_emul_pcie_ss_axis_wrr_sched_if #(.NUM_CH(2)) bus2 ();
  ase_emul_pcie_ss_axis_wrr_sched_if #(.NUM_CH(3)) bus3 ();

  ase_emul_pcie_ss_axis_wrr_sched #(.NUM_CH(2), .WEIGHT_W(4), .STARVE_W(8), .STARVE_LIMIT(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .weight_cfg(weight2), .cur_ch(cur2)
  );

  ase_emul_pcie_ss_axis_wrr_sched #(.NUM_CH(3), .WEIGHT_W(4), .STARVE_W(8), .STARVE_LIMIT(200)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .weight_cfg(weight3), .cur_ch(cur3)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [1:0] rl;
    logic       rdy;
    logic [3:0] w0;
    logic [3:0] w1;
    logic       gv;
    logic [0:0] gidx;
    logic [0:0] cur;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic rst, input logic [1:0] rv, input logic [1:0] rl,
                              input logic rdy, input logic [3:0] w0, input logic [3:0] w1,
                              input logic gv, input logic [0:0] gidx, input logic [0:0] cur);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rl = rl; v.rdy = rdy; v.w0 = w0; v.w1 = w1;
    v.gv = gv; v.gidx = gidx; v.cur = cur;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_both();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  function automatic int grant2();
    return bus2.grant_valid ? int'(bus2.grant_idx) : -1;
  endfunction

  function automatic int grant3();
    return bus3.grant_valid ? int'(bus3.grant_idx) : -1;
  endfunction

  int exp3[6] = '{1, 0, 0, 1, 0, 0};

  initial begin
    int c0, c1, pat_bad, ch0_beats, found, seen, exp_beats;
    logic [1:0] exp_1hot;

    bus2.req_valid = '0; bus2.req_last = '0; bus2.out_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_last = '0; bus3.out_ready = 1'b0;
    weight2 = '0; weight3 = '0;

    //          rst rv     rl     rdy w0 w1  gv gidx cur
    vecs[0]  = mk(0, 2'b11, 2'b11, 1, 3, 1,  0, 0, 0);
    vecs[1]  = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 1, 0);
    vecs[2]  = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 1);
    vecs[3]  = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 0);
    vecs[4]  = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 0);
    vecs[5]  = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 1, 0);
    vecs[6]  = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 1);
    vecs[7]  = mk(1, 2'b11, 2'b11, 0, 3, 1,  0, 0, 0);
    vecs[8]  = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 0);
    vecs[9]  = mk(1, 2'b11, 2'b00, 1, 3, 1,  1, 0, 0);
    vecs[10] = mk(1, 2'b10, 2'b00, 1, 3, 1,  0, 0, 0);
    vecs[11] = mk(1, 2'b11, 2'b00, 1, 3, 1,  1, 0, 0);
    vecs[12] = mk(1, 2'b11, 2'b01, 1, 3, 1,  1, 0, 0);
    vecs[13] = mk(1, 2'b11, 2'b00, 1, 3, 1,  1, 1, 0);
    vecs[14] = mk(1, 2'b11, 2'b00, 0, 3, 1,  0, 0, 1);
    vecs[15] = mk(1, 2'b11, 2'b00, 1, 3, 1,  1, 1, 1);
    vecs[16] = mk(1, 2'b11, 2'b00, 0, 3, 1,  0, 0, 1);
    vecs[17] = mk(1, 2'b11, 2'b10, 1, 3, 1,  1, 1, 1);
    vecs[18] = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 1);
    vecs[19] = mk(1, 2'b11, 2'b11, 1, 1, 1,  1, 0, 0);
    vecs[20] = mk(1, 2'b11, 2'b11, 1, 1, 1,  1, 0, 0);
    vecs[21] = mk(1, 2'b11, 2'b11, 1, 1, 1,  1, 1, 0);
    vecs[22] = mk(1, 2'b11, 2'b11, 1, 1, 1,  1, 0, 1);
    vecs[23] = mk(1, 2'b11, 2'b11, 1, 1, 1,  1, 1, 0);
    vecs[24] = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 1);
    vecs[25] = mk(1, 2'b10, 2'b11, 1, 3, 1,  1, 1, 0);
    vecs[26] = mk(1, 2'b10, 2'b11, 1, 3, 1,  1, 1, 1);
    vecs[27] = mk(1, 2'b10, 2'b11, 1, 3, 1,  1, 1, 1);
    vecs[28] = mk(1, 2'b10, 2'b00, 1, 3, 1,  1, 1, 1);
    vecs[29] = mk(0, 2'b11, 2'b00, 1, 3, 1,  0, 0, 0);
    vecs[30] = mk(1, 2'b01, 2'b11, 1, 3, 1,  1, 0, 0);
    vecs[31] = mk(1, 2'b11, 2'b11, 1, 3, 1,  1, 0, 0);

    next_cycle();
    for (int i = 0; i < 32; i++) begin
      rst_n          = vecs[i].rst;
      bus2.req_valid = vecs[i].rv;
      bus2.req_last  = vecs[i].rl;
      bus2.out_ready = vecs[i].rdy;
      weight2        = {vecs[i].w1, vecs[i].w0};
      exp_1hot       = vecs[i].gv ? (2'b01 << vecs[i].gidx) : 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_grant_valid", i), int'(bus2.grant_valid), int'(vecs[i].gv));
      chk($sformatf("v%0d_grant_idx", i), int'(bus2.grant_idx), int'(vecs[i].gidx));
      chk($sformatf("v%0d_grant_1hot", i), int'(bus2.grant_1hot), int'(exp_1hot));
      chk($sformatf("v%0d_cur_ch", i), int'(cur2), int'(vecs[i].cur));
      next_cycle();
    end
    rst_n = 1'b1;

    // weights 3,1 streaming single-beat packets: 1,0,0,0 repeating from reset
    reset_both();
    bus2.req_valid = 2'b11; bus2.req_last = 2'b11; bus2.out_ready = 1'b1;
    weight2 = {4'd1, 4'd3};
    c0 = 0; c1 = 0; pat_bad = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!bus2.grant_valid) pat_bad++;
      else if (bus2.grant_idx == 1'b1) begin
        c1++;
        if (k % 4 != 0) pat_bad++;
      end else begin
        c0++;
        if (k % 4 == 0) pat_bad++;
      end
      next_cycle();
    end
    chk("ratio_ch0_beats", c0, 300);
    chk("ratio_ch1_beats", c1, 100);
    chk("ratio_pattern_errors", pat_bad, 0);

    // three channels, ch1 weight 0 (acts as 1), ch0 weight 2, ch2 idle then joining
    bus2.req_valid = '0;
    reset_both();
    bus3.req_valid = 3'b011; bus3.req_last = 3'b111; bus3.out_ready = 1'b1;
    weight3 = {4'd1, 4'd0, 4'd2};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("wrr3_seq%0d", i), grant3(), exp3[i]);
      next_cycle();
    end
    bus3.req_valid = 3'b111;
    found = 0;
    for (int i = 0; i < 4 && found == 0; i++) begin
      @(negedge clk);
      if (grant3() == 2) found = 1;
      next_cycle();
    end
    chk("wrr3_ch2_granted_within_turn", found, 1);
    bus3.req_valid = '0;

    // ch0 8-beat packets at weight 15 against a single-beat ch1 stream
    reset_both();
    weight2 = {4'd1, 4'd15};
    bus2.req_valid = 2'b11; bus2.req_last = 2'b10; bus2.out_ready = 1'b1;
    @(negedge clk);
    chk("starve_first_grant", grant2(), 1);
    next_cycle();
    ch0_beats = 0; seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      bus2.req_last = {1'b1, (ch0_beats % 8 == 7)};
      @(negedge clk);
      if (grant2() == 1) seen = 1;
      else if (grant2() == 0) ch0_beats++;
      next_cycle();
    end
`ifdef ASE_EMUL_PCIE_SS_SCHED_STARVE_GUARD_EN
    exp_beats = 24;
`else
    exp_beats = 120;
`endif
    chk("starve_ch1_granted", seen, 1);
    chk("starve_ch0_beats_before_ch1", ch0_beats, exp_beats);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
